// File: rtl/lt24_pixel_bus_writer_pkg.sv
// Shared types and constants for the LT24 pixel bus writer: panel geometry,
// ILI9341 command codes, FSM encoding and the bus word payload.
package lt24_pixel_bus_writer_pkg;

    localparam int unsigned LCD_WIDTH_DEF  = 240;
    localparam int unsigned LCD_HEIGHT_DEF = 320;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(4);

    localparam logic [BYTE_W-1:0] CMD_CASET = 8'h2A;
    localparam logic [BYTE_W-1:0] CMD_PASET = 8'h2B;
    localparam logic [BYTE_W-1:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_PIXEL
    } state_e;

    typedef struct packed {
        logic             rs;
        logic [PIX_W-1:0] data;
    } bus_word_t;

    // Command byte: RS low, byte on the low lane.
    function automatic bus_word_t cmd_word(input logic [BYTE_W-1:0] code);
        bus_word_t w;
        w.rs   = 1'b0;
        w.data = {8'h00, code};
        return w;
    endfunction

    // Parameter byte: RS high, byte on the low lane.
    function automatic bus_word_t par_word(input logic [BYTE_W-1:0] val);
        bus_word_t w;
        w.rs   = 1'b1;
        w.data = {8'h00, val};
        return w;
    endfunction

endpackage

// File: rtl/lt24_bus_word.sv
// Emits one 8080 write cycle: Wr_n low for WR_LOW_CYCLES, then high for
// WR_HIGH_CYCLES with RS/Data held; done marks the last high-phase cycle.
module lt24_bus_word #(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetApp,
    input  logic        start,
    input  logic        rs,
    input  logic [15:0] data,
    output logic        bus_wr_n,
    output logic        bus_rs,
    output logic [15:0] bus_data,
    output logic        done
);

    localparam int unsigned CNT_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    logic             busy_q, busy_d;
    logic             high_q, high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_n_q, wr_n_d;
    logic             rs_q, rs_d;
    logic [15:0]      data_q, data_d;
    logic             done_q, done_d;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            busy_q <= 1'b0;
            high_q <= 1'b0;
            cnt_q  <= '0;
            wr_n_q <= 1'b1;
            rs_q   <= 1'b1;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            high_q <= high_d;
            cnt_q  <= cnt_d;
            wr_n_q <= wr_n_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    // A start in the done cycle chains the next word with no idle gap.
    always_comb begin
        busy_d = busy_q;
        high_d = high_q;
        cnt_d  = cnt_q;
        wr_n_d = wr_n_q;
        rs_d   = rs_q;
        data_d = data_q;
        if (start) begin
            busy_d = 1'b1;
            high_d = 1'b0;
            wr_n_d = 1'b0;
            rs_d   = rs;
            data_d = data;
            cnt_d  = CNT_W'(WR_LOW_CYCLES - 1);
        end else if (busy_q) begin
            if (!high_q) begin
                if (cnt_q == '0) begin
                    high_d = 1'b1;
                    wr_n_d = 1'b1;
                    cnt_d  = CNT_W'(WR_HIGH_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        done_d = busy_d && high_d && (cnt_d == '0);
    end

    assign bus_wr_n = wr_n_q;
    assign bus_rs   = rs_q;
    assign bus_data = data_q;
    assign done     = done_q;

endmodule

// File: rtl/lt24_pixel_bus_writer.sv
// Pixel-write responder: turns one (x, y, colour) handshake into either a
// full CASET/PASET/RAMWR/pixel sequence or a single continuation data word.
module lt24_pixel_bus_writer
    import lt24_pixel_bus_writer_pkg::*;
#(
    parameter int unsigned LCD_WIDTH      = LCD_WIDTH_DEF,
    parameter int unsigned LCD_HEIGHT     = LCD_HEIGHT_DEF,
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             resetApp,
    input  logic [X_W-1:0]   xAddr,
    input  logic [Y_W-1:0]   yAddr,
    input  logic [PIX_W-1:0] pixelData,
    input  logic             pixelWrite,
    output logic             pixelReady,
    output logic             LT24Wr_n,
    output logic             LT24Rd_n,
    output logic             LT24CS_n,
    output logic             LT24RS,
    output logic [PIX_W-1:0] LT24Data
);

    localparam logic [15:0] W_LAST = 16'(LCD_WIDTH - 1);
    localparam logic [15:0] H_LAST = 16'(LCD_HEIGHT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ready_q, ready_d;
    logic               cs_n_q, cs_n_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [X_W-1:0]     last_x_q, last_x_d;
    logic [Y_W-1:0]     last_y_q, last_y_d;
    logic               cont_q, cont_d;

    logic               start_c;
    bus_word_t          word_c;
    logic               word_done;
    logic               in_range_c;
    logic               fast_c;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            pix_q    <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            cs_n_q   <= cs_n_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pix_q    <= pix_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            cont_q   <= cont_d;
        end
    end

    // x+1 at 9 bits so column 255 cannot alias onto column 0.
    assign in_range_c = (32'(x_q) < LCD_WIDTH) && (32'(y_q) < LCD_HEIGHT);
    assign fast_c     = cont_q && (y_q == last_y_q) && (9'(x_q) == 9'(last_x_q) + 9'd1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ready_d  = ready_q;
        cs_n_d   = cs_n_q;
        x_d      = x_q;
        y_d      = y_q;
        pix_d    = pix_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        cont_d   = cont_q;
        start_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                if (ready_q && pixelWrite) begin
                    x_d     = xAddr;
                    y_d     = yAddr;
                    pix_d   = pixelData;
                    ready_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!in_range_c) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cs_n_d  = 1'b0;
                    start_c = 1'b1;
                    if (fast_c) begin
                        state_d = ST_PIXEL;
                    end else begin
                        state_d = ST_CASET;
                        idx_d   = '0;
                    end
                end
            end
            ST_CASET: begin
                if (word_done) begin
                    start_c = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PASET;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PASET: begin
                if (word_done) begin
                    start_c = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RAMWR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RAMWR: begin
                if (word_done) begin
                    start_c = 1'b1;
                    state_d = ST_PIXEL;
                end
            end
            ST_PIXEL: begin
                if (word_done) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b1;
                    cs_n_d   = 1'b1;
                    last_x_d = x_q;
                    last_y_d = y_q;
                    cont_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload of the word about to be launched, keyed by the state it belongs to.
    always_comb begin
        word_c = par_word(8'h00);
        case (state_d)
            ST_CASET: begin
                case (idx_d)
                    3'd0:    word_c = cmd_word(CMD_CASET);
                    3'd1:    word_c = par_word(8'h00);
                    3'd2:    word_c = par_word(x_q);
                    3'd3:    word_c = par_word(W_LAST[15:8]);
                    default: word_c = par_word(W_LAST[7:0]);
                endcase
            end
            ST_PASET: begin
                case (idx_d)
                    3'd0:    word_c = cmd_word(CMD_PASET);
                    3'd1:    word_c = par_word({7'b0, y_q[8]});
                    3'd2:    word_c = par_word(y_q[7:0]);
                    3'd3:    word_c = par_word(H_LAST[15:8]);
                    default: word_c = par_word(H_LAST[7:0]);
                endcase
            end
            ST_RAMWR: word_c = cmd_word(CMD_RAMWR);
            ST_PIXEL: begin
                word_c.rs   = 1'b1;
                word_c.data = pix_q;
            end
            default: ;
        endcase
    end

    lt24_bus_word #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
    ) u_bus_word (
        .clock   (clock),
        .resetApp(resetApp),
        .start   (start_c),
        .rs      (word_c.rs),
        .data    (word_c.data),
        .bus_wr_n(LT24Wr_n),
        .bus_rs  (LT24RS),
        .bus_data(LT24Data),
        .done    (word_done)
    );

    assign pixelReady = ready_q;
    assign LT24CS_n   = cs_n_q;
    assign LT24Rd_n   = 1'b1;

endmodule

// File: tb/tb_lt24_pixel_bus_writer.sv
// Self-checking bench for lt24_pixel_bus_writer: a cycle-level expectation
// derived from word lists and bus timing arithmetic, plus literal sequences.
module tb_lt24_pixel_bus_writer;

    localparam int W   = 240;
    localparam int H   = 320;
    localparam int LO  = 2;
    localparam int HI  = 2;
    localparam int PER = LO + HI;

    logic        clock = 1'b0;
    logic        resetApp = 1'b1;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;
    logic        pixelWrite = 1'b0;
    logic        pixelReady;
    logic        LT24Wr_n;
    logic        LT24Rd_n;
    logic        LT24CS_n;
    logic        LT24RS;
    logic [15:0] LT24Data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    lt24_pixel_bus_writer dut (
        .clock     (clock),
        .resetApp  (resetApp),
        .xAddr     (xAddr),
        .yAddr     (yAddr),
        .pixelData (pixelData),
        .pixelWrite(pixelWrite),
        .pixelReady(pixelReady),
        .LT24Wr_n  (LT24Wr_n),
        .LT24Rd_n  (LT24Rd_n),
        .LT24CS_n  (LT24CS_n),
        .LT24RS    (LT24RS),
        .LT24Data  (LT24Data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Word list a pixel must produce, straight from the addressing rules.
    task automatic model_words(input int x, input int y, input logic [15:0] pix, input bit cont,
                               input int lx, input int ly, output int n, output logic [11:0][16:0] w);
        w = '0;
        if (x >= W || y >= H) begin
            n = 0;
        end else if (cont && y == ly && x == lx + 1) begin
            n = 1;
            w[0] = {1'b1, pix};
        end else begin
            n = 12;
            w[0]  = {1'b0, 16'h002A};
            w[1]  = {1'b1, 16'h0000};
            w[2]  = {1'b1, 16'(x)};
            w[3]  = {1'b1, 16'((W - 1) / 256)};
            w[4]  = {1'b1, 16'((W - 1) % 256)};
            w[5]  = {1'b0, 16'h002B};
            w[6]  = {1'b1, 16'(y / 256)};
            w[7]  = {1'b1, 16'(y % 256)};
            w[8]  = {1'b1, 16'((H - 1) / 256)};
            w[9]  = {1'b1, 16'((H - 1) % 256)};
            w[10] = {1'b0, 16'h002C};
            w[11] = {1'b1, pix};
        end
    endtask

    // Reference state: d counts cycles since the accepting edge.
    bit m_active = 0, m_pend = 0, m_ready = 0, m_rst_pend = 0, m_cont = 0;
    int m_d = 0, m_n = 0, m_lx = 0, m_ly = 0;
    logic [11:0][16:0] m_w;

    initial begin
        forever begin
            @(negedge clock);
            if (resetApp) begin
                m_active = 0; m_pend = 0; m_ready = 0; m_cont = 0; m_rst_pend = 1;
                check("rst_ready", 32'(pixelReady), 0);
                check("rst_wr_n", 32'(LT24Wr_n), 1);
                check("rst_cs_n", 32'(LT24CS_n), 1);
                check("rst_rs", 32'(LT24RS), 1);
                check("rst_data", 32'(LT24Data), 0);
                check("rst_rd_n", 32'(LT24Rd_n), 1);
            end else begin
                if (m_rst_pend) begin m_rst_pend = 0; m_ready = 1; end
                if (m_pend) begin
                    m_pend = 0; m_active = 1; m_d = 0;
                end else if (m_active) begin
                    m_d++;
                    if (m_d == PER * m_n + 1) begin m_active = 0; m_ready = 1; end
                end
                if (m_active) begin
                    bit in_word;
                    in_word = (m_d >= 1) && (m_d <= PER * m_n);
                    check("cyc_ready", 32'(pixelReady), 0);
                    check("cyc_cs_n", 32'(LT24CS_n), 32'(!in_word));
                    check("cyc_wr_n", 32'(LT24Wr_n), 32'(!(in_word && ((m_d - 1) % PER) < LO)));
                    if (in_word) check("cyc_word", 32'({LT24RS, LT24Data}), 32'(m_w[(m_d - 1) / PER]));
                end else begin
                    check("idle_ready", 32'(pixelReady), 32'(m_ready));
                    check("idle_wr_n", 32'(LT24Wr_n), 1);
                    check("idle_cs_n", 32'(LT24CS_n), 1);
                end
                check("rd_n", 32'(LT24Rd_n), 1);
                if (!m_active && m_ready && pixelWrite) begin
                    model_words(int'(xAddr), int'(yAddr), pixelData, m_cont, m_lx, m_ly, m_n, m_w);
                    if (m_n > 0) begin m_cont = 1; m_lx = int'(xAddr); m_ly = int'(yAddr); end
                    m_pend = 1; m_ready = 0;
                end
            end
        end
    end

    int n_fall = 0;
    logic [16:0] cap[$];

    initial forever begin
        @(negedge LT24Wr_n);
        if (!resetApp) n_fall++;
    end

    initial forever begin
        @(posedge LT24Wr_n);
        if (!resetApp) cap.push_back({LT24RS, LT24Data});
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int x, input int y, input logic [15:0] d, input bit hold);
        int cnt;
        bit hs;
        cnt = 0; hs = 0;
        xAddr = 8'(x); yAddr = 9'(y); pixelData = d; pixelWrite = 1'b1;
        while (!hs && cnt < 300) begin
            @(negedge clock);
            hs = pixelReady;
            @(posedge clock);
            cnt++;
        end
        #1;
        if (!hold) pixelWrite = 1'b0;
        if (!hs) check("handshake_timeout", 0, 1);
    endtask

    task automatic latency(output int k);
        k = 0;
        do begin
            @(posedge clock); #1; k++;
        end while (!pixelReady && k < 200);
    endtask

    logic [16:0] exp1 [12] = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h100EF,
                               17'h0002B, 17'h10000, 17'h10014, 17'h10001, 17'h1003F,
                               17'h0002C, 17'h1F800};

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, lat, f0, px, py;
        logic [11:0][16:0] w;
        logic [15:0] pix [240];

        // Pin the reference against hand-computed sequences.
        model_words(10, 20, 16'hF800, 0, 0, 0, n, w);
        check("model_full_n", 32'(n), 12);
        for (int i = 0; i < 12; i++) check("model_full_word", 32'(w[i]), 32'(exp1[i]));
        model_words(11, 20, 16'h07E0, 1, 10, 20, n, w);
        check("model_fast_n", 32'(n), 1);
        check("model_fast_word", 32'(w[0]), 32'h107E0);
        model_words(0, 21, 16'h1234, 1, 239, 20, n, w);
        check("model_wrap_n", 32'(n), 12);
        check("model_wrap_y", 32'(w[7]), 32'h10015);
        model_words(240, 0, 16'h1234, 1, 239, 0, n, w);
        check("model_oor_n", 32'(n), 0);

        repeat (3) @(negedge clock);
        #1 resetApp = 1'b0;
        @(posedge clock); #1;
        check("ready_after_release", 32'(pixelReady), 1);

        // First pixel: full sequence.
        cap.delete(); f0 = n_fall;
        send(10, 20, 16'hF800, 0);
        check("full_ready_drop", 32'(pixelReady), 0);
        latency(lat);
        check("full_latency", 32'(lat), 49);
        check("full_pulses", 32'(n_fall - f0), 12);
        check("full_cap_size", 32'(cap.size()), 12);
        for (int i = 0; i < 12; i++) check("full_cap_word", 32'(cap[i]), 32'(exp1[i]));

        // Continuation: single data word.
        cap.delete(); f0 = n_fall;
        send(11, 20, 16'h07E0, 0);
        latency(lat);
        check("fast_latency", 32'(lat), 5);
        check("fast_pulses", 32'(n_fall - f0), 1);
        check("fast_word", 32'(cap[0]), 32'h107E0);

        // Row wrap goes back to the full path.
        send(239, 20, 16'($urandom), 0); latency(lat);
        cap.delete();
        send(0, 21, 16'($urandom), 0); latency(lat);
        check("wrap_cap_size", 32'(cap.size()), 12);
        check("wrap_x", 32'(cap[2]), 32'h10000);
        check("wrap_yh", 32'(cap[6]), 32'h10000);
        check("wrap_yl", 32'(cap[7]), 32'h10015);

        // Out-of-range pixels are dropped without disturbing continuation.
        send(11, 20, 16'($urandom), 0); latency(lat);
        f0 = n_fall;
        send(240, 0, 16'($urandom), 0); latency(lat);
        check("oor_x_latency", 32'(lat), 1);
        send(0, 320, 16'($urandom), 0); latency(lat);
        check("oor_y_latency", 32'(lat), 1);
        check("oor_pulses", 32'(n_fall - f0), 0);
        send(12, 20, 16'($urandom), 0); latency(lat);
        check("oor_then_fast_pulses", 32'(n_fall - f0), 1);

        // Row sweep with pixelWrite held high.
        for (int i = 0; i < 240; i++) pix[i] = 16'($urandom);
        cap.delete(); f0 = n_fall;
        for (int i = 0; i < 240; i++) send(i, 5, pix[i], 1);
        pixelWrite = 1'b0;
        latency(lat);
        check("sweep_pulses", 32'(n_fall - f0), 251);
        check("sweep_cap_size", 32'(cap.size()), 251);
        check("sweep_first_pix", 32'(cap[11]), 32'({1'b1, pix[0]}));
        for (int i = 1; i < 240; i++) check("sweep_pix", 32'(cap[11 + i]), 32'({1'b1, pix[i]}));

        // Random mix of continuing, jumping and out-of-range pixels.
        px = 0; py = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1 && px < 255) begin
                px = px + 1;
            end else begin
                px = int'($urandom_range(0, 255));
                py = int'($urandom_range(0, 340));
            end
            send(px, py, 16'($urandom), 0);
            latency(lat);
        end

        // Reset during the PASET words abandons the write and clears continuation.
        send(50, 50, 16'($urandom), 0); latency(lat);
        send(100, 300, 16'($urandom), 0);
        repeat (25) @(posedge clock);
        #2 resetApp = 1'b1;
        #1;
        check("midrst_wr_n", 32'(LT24Wr_n), 1);
        check("midrst_cs_n", 32'(LT24CS_n), 1);
        check("midrst_ready", 32'(pixelReady), 0);
        repeat (2) @(negedge clock);
        #1 resetApp = 1'b0;
        @(posedge clock); #1;
        check("midrst_ready_back", 32'(pixelReady), 1);
        f0 = n_fall;
        send(101, 300, 16'($urandom), 0);
        latency(lat);
        check("midrst_latency", 32'(lat), 49);
        check("midrst_pulses", 32'(n_fall - f0), 12);

        repeat (4) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lt24_pixel_bus_writer.md
Name: lt24_pixel_bus_writer

Overview:
- Responder side of the team's pixel-write interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
- Accepts one pixel per handshake and converts it into ILI9341-style 8080 parallel write cycles on the LT24 bus.
- Full-address path: CASET, PASET, RAMWR, then the pixel word.
- Fast path: a single data word when the pixel directly continues the previous one in the same row.
- Sits between any pixel producer (e.g. the chess renderer) and the LT24 pins. Panel power-up and initialisation are done upstream before resetApp deasserts.

Parameters:
- LCD_WIDTH, 240, columns; CASET end column = LCD_WIDTH-1.
- LCD_HEIGHT, 320, rows; PASET end row = LCD_HEIGHT-1.
- WR_LOW_CYCLES, 2, clocks LT24Wr_n is held low per bus word (>=1).
- WR_HIGH_CYCLES, 2, clocks LT24Wr_n is held high after each word (>=1).

Ports:
- clock  in  1  system clock
- resetApp  in  1  reset, asynchronous, active-high
- xAddr  in  8  pixel column
- yAddr  in  9  pixel row
- pixelData  in  16  RGB565 pixel
- pixelWrite  in  1  producer request
- pixelReady  out  1  block can accept a pixel this cycle
- LT24Wr_n  out  1  write strobe, active-low
- LT24Rd_n  out  1  read strobe; tied 1
- LT24CS_n  out  1  chip select, active-low
- LT24RS  out  1  0 = command word, 1 = data word
- LT24Data  out  16  bus data; commands and parameters on [7:0], [15:8] = 0

Behaviour:
- Reset values: pixelReady=0, LT24Wr_n=1, LT24Rd_n=1, LT24CS_n=1, LT24RS=1, LT24Data=0. State IDLE, contVld=0.
- pixelReady rises on the first clock after reset release.
- Handshake:
  - Transfer occurs on any edge where pixelWrite && pixelReady; x, y and data are captured into registers.
  - pixelReady drops on the next cycle and stays low until the transaction completes.
  - A producer holding pixelWrite=1 permanently is legal.
- Range check: x>=LCD_WIDTH or y>=LCD_HEIGHT.
  - Pixel is dropped: no bus activity, contVld unchanged.
  - pixelReady is low for exactly 1 cycle.
- Path selection:
  - Fast path when contVld && y==lastY && x==lastX+1: 1 data word (RS=1, pixelData).
  - Otherwise full path, 12 words in order:
    - 0x2A, 0x00, x, (W-1)>>8, (W-1)&0xFF
    - 0x2B, y>>8, y&0xFF, (H-1)>>8, (H-1)&0xFF
    - 0x2C, pixelData
  - RS=0 on the 0x2A, 0x2B and 0x2C words only.
- Bus word timing:
  - RS and Data become valid in the same cycle LT24Wr_n falls.
  - LT24Wr_n is low for WR_LOW_CYCLES, then high for WR_HIGH_CYCLES.
  - RS and Data are held through the whole high phase; the panel latches on the rising edge of Wr_n.
- LT24CS_n is low from the first word's falling edge to the end of the last word's high phase, and high in IDLE.
- Latency: if the pixel is accepted at edge N, pixelReady is high again at edge N + words*(WR_LOW_CYCLES+WR_HIGH_CYCLES) + 1.
  - Defaults: full path 49, fast path 5.
- After any completed write: lastX=x, lastY=y, contVld=1.
- x==LCD_WIDTH-1 is a legal pixel, but x+1 never matches, so row wrap always takes the full path.
- FSM states: IDLE, CHECK, CASET, PASET, RAMWR, PIXEL.
  - Each of CASET and PASET owns a 0..4 word index; RAMWR is 1 word; PIXEL is 1 word.
  - CHECK evaluates range and path.
  - Fast path: CHECK -> PIXEL -> IDLE.
  - Full path: CHECK -> CASET -> PASET -> RAMWR -> PIXEL -> IDLE.
  - Out-of-range: CHECK -> IDLE.
- Arithmetic: x+1 is computed at 9 bits (no 8-bit wrap to 0); parameter bytes use the unsigned widths shown.
- Reset mid-transaction: outputs go to reset values asynchronously and contVld clears, so the next pixel takes the full path. A partially written command is abandoned.

Decomposition:
- Shared package: LCD_WIDTH/LCD_HEIGHT defaults; command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C; the FSM state encoding.
- Sub-module lt24_bus_word:
  - Inputs: start, rs, data.
  - Outputs: Wr_n, RS, Data, done.
  - Runs the low/high phase counters; done pulses in the final high-phase cycle.
  - Parent FSM sequences the words.

Test Plan:
- Reset release, then (10,20,0xF800): 12 words 0x2A,0x00,0x0A,0x00,0xEF,0x2B,0x00,0x14,0x01,0x3F,0x2C,0xF800; RS pattern 0,1,1,1,1,0,1,1,1,1,0,1; pixelReady low 48 cycles; CS_n low throughout.
- Then (11,20,0x07E0): single word RS=1, Data=0x07E0, exactly one Wr_n low pulse of 2 cycles, pixelReady high 5 edges after accept.
- (239,20) then (0,21): second pixel emits full 12-word sequence with x byte 0x00, y bytes 0x00,0x15.
- (240,0) and (0,320): no Wr_n falling edge, CS_n stays 1, pixelReady low exactly 1 cycle each; a following (12,20) after prior (11,20) still uses the fast path.
- pixelWrite held 1, producer sweeps row y=5 x=0..239: 1 full sequence + 239 single data words; 251 Wr_n pulses total; every pixel value appears once in order.
- Assert resetApp during the PASET words: Wr_n=1, CS_n=1, pixelReady=0 immediately; after release (the next sequential x) takes the full path.
